vram_fetch_scheduler: RTL and testbench

//  Shares one single-port video RAM (1-cycle read latency) between the pixel fetch path and a host port.

---
 rtl/vram_fetch_scheduler.sv | 154 +++++++++++++++
 tb/tb_vram_fetch_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_scheduler.sv
// Arbitrates a single-port video RAM between a per-8-pixel video fetch and a host port,
// and serialises fetched bytes MSB-first into a 1bpp pixel stream.
module vram_fetch_scheduler #(
    parameter int H_DISPLAY      = 640,
    parameter int H_TOTAL        = 800,
    parameter int V_DISPLAY      = 480,
    parameter int V_TOTAL        = 525,
    parameter int H_LEN          = 9,
    parameter int V_LEN          = 9,
    parameter int ADDR_W         = 16,
    parameter bit HOST_ACTIVE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              display_on,
    input  logic [H_LEN:0]    hpos,
    input  logic [V_LEN:0]    vpos,
    input  logic [ADDR_W-1:0] fb_base,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [7:0]        host_rdata,
    output logic              pix_out
);

    localparam int TX_W    = H_LEN + 2;
    localparam int V_LAST  = V_TOTAL - 1;
    localparam int H_WORDS = H_DISPLAY / 8;

    localparam logic [TX_W-1:0]   L_TX_TOTAL = TX_W'(H_TOTAL);
    localparam logic [TX_W-1:0]   L_TX_DISP  = TX_W'(H_DISPLAY);
    localparam logic [H_LEN:0]    L_H_DISP   = (H_LEN+1)'(H_DISPLAY);
    localparam logic [V_LEN:0]    L_V_DISP   = (V_LEN+1)'(V_DISPLAY);
    localparam logic [V_LEN:0]    L_V_LAST   = (V_LEN+1)'(V_LAST);
    localparam logic [ADDR_W-1:0] L_H_WORDS  = ADDR_W'(H_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOST  = 2'd1,
        ST_VIDEO = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]        w_slot;
    logic [TX_W-1:0]   w_tx_raw;
    logic [TX_W-1:0]   w_tx;
    logic [V_LEN:0]    w_tline;
    logic              w_fetch;
    logic              w_fetch_now;
    logic              w_host_ok;
    logic              w_accept;
    logic [ADDR_W-1:0] w_vid_addr;

    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [7:0]        r_ram_wdata;
    logic              r_rvalid;
    logic              r_fetch_grp;
    logic [7:0]        r_sr;
    logic [ADDR_W-1:0] r_base;

    // Target of the decision taken in slot 5: the next 8-pixel group, possibly on the next line.
    assign w_slot      = hpos[2:0];
    assign w_tx_raw    = (TX_W'(hpos) | TX_W'(7)) + TX_W'(1);
    assign w_tx        = (w_tx_raw == L_TX_TOTAL) ? '0 : w_tx_raw;
    assign w_tline     = (hpos >= L_H_DISP) ? ((vpos == L_V_LAST) ? '0 : vpos + 1'b1) : vpos;
    assign w_fetch     = (w_tx < L_TX_DISP) && (w_tline < L_V_DISP);
    assign w_fetch_now = (w_slot == 3'd5) && w_fetch;
    assign w_vid_addr  = r_base + ADDR_W'(w_tline) * L_H_WORDS + ADDR_W'(w_tx[TX_W-1:3]);

    assign w_host_ok   = HOST_ACTIVE_EN || (vpos >= L_V_DISP);
    assign host_ready  = ~w_fetch_now & w_host_ok;
    assign w_accept    = host_valid & host_ready;

    // Next port owner; the RAM command registers are loaded for that owner on the same edge.
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_fetch_now) begin
            w_state_next = ST_VIDEO;
        end else if (w_accept) begin
            w_state_next = ST_HOST;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 8'h00;
            r_rvalid    <= 1'b0;
            r_fetch_grp <= 1'b0;
            r_sr        <= 8'h00;
            r_base      <= '0;
        end else begin
            // A host read owning the port this cycle returns data in the following cycle.
            r_rvalid <= (r_state == ST_HOST) && !r_ram_we;

            case (w_state_next)
                ST_VIDEO: begin
                    r_ram_addr <= w_vid_addr;
                    r_ram_we   <= 1'b0;
                end
                ST_HOST: begin
                    r_ram_addr  <= host_addr;
                    r_ram_we    <= host_we;
                    r_ram_wdata <= host_wdata;
                end
                default: begin
                    r_ram_we <= 1'b0;
                end
            endcase

            if (w_slot == 3'd5) begin
                r_fetch_grp <= w_fetch;
            end

            if (w_slot == 3'd7) begin
                r_sr <= r_fetch_grp ? ram_rdata : 8'h00;
            end else begin
                r_sr <= {r_sr[6:0], 1'b0};
            end

            // Base is only picked up at the start of vblank so a frame never mixes two buffers.
            if ((hpos == '0) && (vpos == L_V_DISP)) begin
                r_base <= fb_base;
            end
        end
    end

    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_wdata   = r_ram_wdata;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rvalid ? ram_rdata : 8'h00;
    assign pix_out     = display_on & r_sr[7];

endmodule

// File: tb/tb_vram_fetch_scheduler.sv
// Directed bench for vram_fetch_scheduler: drives raster positions directly and models the RAM.
module tb_vram_fetch_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        display_on = 1'b0;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic [15:0] fb_base = '0;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        host_valid = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ready;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        pix_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:65535];
    logic       written [0:65535];

    vram_fetch_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .display_on  (display_on),
        .hpos        (hpos),
        .vpos        (vpos),
        .fb_base     (fb_base),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .host_valid  (host_valid),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ready  (host_ready),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .pix_out     (pix_out)
    );

    always #5 clk = ~clk;

    // Unwritten locations read as their low address byte, except location 0 which holds 8'h81.
    always @(posedge clk) begin
        if (written[ram_addr] === 1'b1) begin
            ram_rdata <= mem[ram_addr];
        end else begin
            ram_rdata <= (ram_addr == 16'h0000) ? 8'h81 : ram_addr[7:0];
        end
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (v=%0d h=%0d)", tag, got, exp, vpos, hpos);
        end else begin
            $display("ok   %s: 0x%0h (v=%0d h=%0d)", tag, got, vpos, hpos);
        end
    endtask

    task automatic upd_disp();
        display_on = (hpos < 10'd640) && (vpos < 10'd480);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (hpos == 10'd799) begin
            hpos = '0;
            vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
        end else begin
            hpos = hpos + 10'd1;
        end
        upd_disp();
        #1;
    endtask

    task automatic set_pos(input int v, input int h);
        vpos = 10'(v);
        hpos = 10'(h);
        upd_disp();
        #1;
    endtask

    task automatic run_to(input int v, input int h);
        for (int n = 0; n < 60000; n++) begin
            if (vpos == 10'(v) && hpos == 10'(h)) break;
            tick();
        end
        chk("run_to", {12'd0, vpos, hpos}, {12'd0, 10'(v), 10'(h)});
    endtask

    initial begin
        int rv_cnt;

        // Reset state
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_rvalid", 32'(host_rvalid), 32'h0);
        chk("rst_pix", 32'(pix_out), 32'h0);
        reset = 1'b1;

        // Reset while a host read is in flight
        set_pos(490, 100);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 16'd100; #1;
        chk("t1_ready", 32'(host_ready), 32'h1);
        tick();
        host_valid = 1'b0;
        chk("t1_addr_pre", 32'(ram_addr), 32'd100);
        reset = 1'b0; #1;
        chk("t1_addr", 32'(ram_addr), 32'h0);
        chk("t1_we", 32'(ram_we), 32'h0);
        chk("t1_rvalid", 32'(host_rvalid), 32'h0);
        chk("t1_rdata", 32'(host_rdata), 32'h0);
        chk("t1_pix", 32'(pix_out), 32'h0);
        tick();
        reset = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (host_rvalid) rv_cnt++;
            tick();
        end
        chk("t1_no_rvalid", 32'(rv_cnt), 32'h0);

        // Fetch addresses, pixel serialisation, host collision with fetch slot
        set_pos(524, 790);
        run_to(524, 798);
        chk("t2_addr_wrap", 32'(ram_addr), 32'h0);
        run_to(0, 0);
        chk("t3_pix_h0", 32'(pix_out), 32'h1);
        for (int h = 1; h <= 4; h++) begin
            tick();
            chk("t3_pix_mid", 32'(pix_out), 32'h0);
        end
        tick();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'h5A; #1;
        chk("t4_ready_s5", 32'(host_ready), 32'h0);
        chk("t3_pix_h5", 32'(pix_out), 32'h0);
        tick();
        chk("t2_addr_g1", 32'(ram_addr), 32'd1);
        chk("t4_ready_s6", 32'(host_ready), 32'h1);
        chk("t4_we_s6", 32'(ram_we), 32'h0);
        chk("t3_pix_h6", 32'(pix_out), 32'h0);
        tick();
        chk("t4_we_s7", 32'(ram_we), 32'h1);
        chk("t4_addr_s7", 32'(ram_addr), 32'h1234);
        chk("t4_wdata_s7", 32'(ram_wdata), 32'h5A);
        chk("t3_pix_h7", 32'(pix_out), 32'h1);
        host_valid = 1'b0; host_we = 1'b0;
        tick();
        chk("t4_we_idle", 32'(ram_we), 32'h0);
        chk("t3_pix_h8", 32'(pix_out), 32'h0);
        chk("t4_mem", 32'(mem[16'h1234]), 32'h5A);
        set_pos(0, 620);
        run_to(0, 630);
        chk("t2_addr_79", 32'(ram_addr), 32'd79);
        run_to(0, 637);
        chk("t3_ready_637", 32'(host_ready), 32'h1);
        run_to(0, 639);
        chk("t3_nofetch_640", 32'(ram_addr), 32'd79);

        // Back-to-back host reads in vblank
        set_pos(490, 200);
        for (int i = 0; i < 8; i++) begin
            host_valid = (i < 4);
            host_we    = 1'b0;
            host_addr  = 16'(100 + i);
            #1;
            if (i < 4) chk("t5_ready", 32'(host_ready), 32'h1);
            chk("t5_rvalid", 32'(host_rvalid), (i >= 2 && i < 6) ? 32'h1 : 32'h0);
            if (i >= 2 && i < 6) chk("t5_rdata", 32'(host_rdata), 32'(100 + i - 2));
            tick();
        end
        host_valid = 1'b0;

        // Base address double buffering
        set_pos(200, 0);
        fb_base = 16'h4000;
        run_to(200, 6);
        chk("t6_old_base", 32'(ram_addr), 32'h3E81);
        set_pos(479, 790);
        run_to(524, 790);
        chk("t6_vblank_nofetch", 32'(ram_addr), 32'h3E81);
        run_to(524, 798);
        chk("t6_new_base0", 32'(ram_addr), 32'h4000);
        run_to(0, 6);
        chk("t6_new_base1", 32'(ram_addr), 32'h4001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
